integer_muldiv_unit: RTL and testbench
======================================

Name: integer_muldiv_unit

Overview:
- Parametrised, multi-cycle successor to the combinational integer ALU; adds the RISC-V M-extension operations.
- Ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the base ALU in the execute stage. The core stalls on in_ready/out_valid.
- Iterative shift-add multiplier and restoring divider share one datapath; one result bit per clock.

Parameters:
- DATA_WIDTH, 32: operand/result width. Even, >= 8.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  DATA_WIDTH  rs1 operand
- B  in  DATA_WIDTH  rs2 operand
- kill  in  1  abort in-flight op (pipeline flush)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out  out  DATA_WIDTH  result, held stable while out_valid=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out=0, counter=0, internal regs=0.
- Accept: handshake when in_valid && in_ready at a rising edge. A, B and funct3 are latched; later changes to them are ignored.
- in_ready is 1 only in IDLE.
- States:
  - IDLE: on accept, go to SPECIAL-check.
  - CALC: runs for DATA_WIDTH cycles.
  - FIX: 1 cycle.
  - DONE.
- Special cases bypass CALC and go IDLE->DONE on the accept edge. out_valid is then asserted in cycle N+1, where N is the accept cycle.
  - Divide by zero: DIV/DIVU give all-ones. REM/REMU give A.
  - Signed overflow (A = most-negative, B = -1): DIV gives A. REM gives 0.
- Normal path:
  - Cycles N+1..N+DATA_WIDTH are CALC; counter counts down from DATA_WIDTH-1 to 0.
  - Cycle N+DATA_WIDTH+1 is FIX.
  - out_valid rises in cycle N+DATA_WIDTH+2. Latency is DATA_WIDTH+2 cycles.
- Operand conditioning, done on accept:
  - Signed operands are converted to magnitude; the result sign is recorded.
  - MULH: both signed. MULHSU: A signed, B unsigned. MULHU, DIVU, REMU: both unsigned.
  - DIV: quotient sign = sign(A) XOR sign(B). REM: remainder takes sign(A).
- Multiply: 2*DATA_WIDTH product register.
  - Each CALC cycle adds the multiplicand when the product LSB is 1, then shifts right.
  - FIX applies two's-complement negate when the result sign is set.
  - MUL returns product[DATA_WIDTH-1:0]. MULH* return product[2*DATA_WIDTH-1:DATA_WIDTH].
- Divide: restoring algorithm on {remainder, quotient}.
  - Each cycle shifts left 1 and trial-subtracts the divisor.
  - If the difference is non-negative, keep it and set quotient LSB to 1.
  - FIX applies the sign correction.
- DONE:
  - out_valid=1 and out holds until out_ready=1 at a rising edge.
  - On that edge go to IDLE: out_valid=0 and in_ready=1 in the next cycle. out keeps its last value.
  - No back-to-back accept in the DONE-exit cycle.
- kill=1 at a rising edge, in any state other than IDLE:
  - Go to IDLE; out_valid=0 next cycle; the result is discarded.
  - kill has priority over out_ready in DONE.
  - kill in IDLE has priority over accept: a request arriving with kill=1 is not accepted.
- Mid-operation reset: all state is cleared immediately, asynchronously. No output glitches to out_valid=1.
- Arithmetic is modulo 2^DATA_WIDTH (2^(2*DATA_WIDTH) for the product). No exceptions or flags.

Test Plan:
- Reset during CALC of DIVU 100/7 -> out_valid=0 and in_ready=1 immediately. A subsequent MUL 3*5 -> 15 at latency 34 (DATA_WIDTH=32).
- MUL A=0xFFFFFFFF (-1), B=0x00000007 -> out=0xFFFFFFF9. MULH same operands -> 0xFFFFFFFF. MULHU same -> 0x00000006. MULHSU A=-1, B=7 -> 0xFFFFFFFF.
- DIV A=-20 (0xFFFFFFEC), B=6 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFE (-2). DIVU 0xFFFFFFEC/6 -> 0x2AAAAAA7. REMU same -> 2.
- DIV by zero: A=0x1234, B=0 -> out=0xFFFFFFFF with out_valid in cycle N+1. REM A=0x1234, B=0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable and in_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- kill asserted at cycle N+10 of MULHU -> IDLE next cycle, no out_valid ever produced for that op. Next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/integer_muldiv_unit.sv
// integer_muldiv_unit: iterative RISC-V M-extension multiply/divide, one result bit per clock
module integer_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int W = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           op;
    logic                 neg;
    logic [W-1:0]         mcand;
    logic [2*W-1:0]       prod;

    logic                 signed_a, signed_b, sa, sb, neg_in, div_zero, ovf;
    logic [W-1:0]         mag_a, mag_b, special_res, fix_res, q, r;
    logic [W:0]           mul_sum;
    logic [W+1:0]         diff;
    logic [2*W-1:0]       calc_next, pm;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Operand conditioning and special-case detection for the request at the inputs
    always_comb begin
        signed_a    = funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110;
        signed_b    = funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110;
        sa          = signed_a && A[W-1];
        sb          = signed_b && B[W-1];
        mag_a       = sa ? -A : A;
        mag_b       = sb ? -B : B;
        neg_in      = (funct3[2] && funct3[1]) ? sa : sa ^ sb;
        div_zero    = funct3[2] && B == '0;
        ovf         = funct3[2] && !funct3[0] && A == {1'b1, {(W-1){1'b0}}} && B == '1;
        special_res = div_zero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : A);
    end

    // One shift-add or restoring-divide step, plus the final sign fix and result select
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, prod[0] ? mcand : {W{1'b0}}};
        diff      = {1'b0, prod[2*W-1:W-1]} - {2'b00, mcand};
        calc_next = op[2] ? (diff[W+1] ? {prod[2*W-2:0], 1'b0} : {diff[W-1:0], prod[W-2:0], 1'b1})
                          : {mul_sum, prod[W-1:1]};
        pm        = neg ? -prod : prod;
        q         = prod[W-1:0];
        r         = prod[2*W-1:W];
        fix_res   = op[2] ? (op[1] ? (neg ? -r : r) : (neg ? -q : q))
                          : (op[1:0] == 2'b00 ? pm[W-1:0] : pm[2*W-1:W]);
    end

    // Control FSM and datapath registers; kill discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            neg   <= 1'b0;
            mcand <= '0;
            prod  <= '0;
            out   <= '0;
        end else if (state != IDLE && kill) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (in_valid && !kill) begin
                op    <= funct3;
                neg   <= neg_in;
                mcand <= funct3[2] ? mag_b : mag_a;
                prod  <= {{W{1'b0}}, funct3[2] ? mag_a : mag_b};
                cnt   <= CNT_WIDTH'(W - 1);
                if (div_zero || ovf) begin
                    out   <= special_res;
                    state <= DONE;
                end else begin
                    state <= CALC;
                end
            end
        end else if (state == CALC) begin
            prod <= calc_next;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
        end else if (state == FIX) begin
            out   <= fix_res;
            state <= DONE;
        end else if (out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_integer_muldiv_unit.sv
// tb_integer_muldiv_unit: directed self-checking bench for integer_muldiv_unit
module tb_integer_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, kill, out_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] A, B, out;
    int          errors = 0;
    int          checks = 0;

    integer_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .A(A), .B(B), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the inputs after accept, then measure latency, result,
    // optional backpressure hold, and the DONE exit.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold);
        int k;
        funct3 = f; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; funct3 = ~f; A = ~a; B = ~b;
        k = 1;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_out"}, out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_out"}, out, exp);
            check({tag, "_hold_flags"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_exit"}, {30'd0, out_valid, in_ready}, 32'd1);
        check({tag, "_keep"}, out, exp);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        funct3 = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 32'd0);
        check("rst_flags", {30'd0, out_valid, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        funct3 = 3'b101; A = 32'd100; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("calc_busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst", {30'd0, out_valid, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);

        run_op("mul",    3'b000, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFF9, 34, 0);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 34, 0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'h7, 32'h00000006, 34, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 34, 0);
        run_op("div",    3'b100, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 34, 0);
        run_op("rem",    3'b110, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 34, 0);
        run_op("divu",   3'b101, 32'hFFFFFFEC, 32'd6, 32'h2AAAAAA7, 34, 0);
        run_op("remu",   3'b111, 32'hFFFFFFEC, 32'd6, 32'h00000002, 34, 0);

        run_op("div0",   3'b100, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op("rem0",   3'b110, 32'h1234, 32'd0, 32'h00001234, 1, 0);
        run_op("divu0",  3'b101, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op("remu0",  3'b111, 32'h1234, 32'd0, 32'h00001234, 1, 0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

        run_op("bp", 3'b101, 32'd100, 32'd7, 32'd14, 34, 10);

        funct3 = 3'b000; A = 32'd3; B = 32'd5; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("idle_kill", {30'd0, out_valid, in_ready}, 32'd1);

        funct3 = 3'b011; A = 32'hFFFFFFFF; B = 32'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_idle", {30'd0, out_valid, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("kill_nov", seen, 32'd0);
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
